// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing x^e mod m by driving an
// external Montgomery multiplier; the block itself only counts bits and muxes operands.
module mont_modexp_ctrl #(
    parameter int WIDTH     = 1024,
    parameter int EXP_WIDTH = 1024,
    parameter int LEN_W     = 11
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [EXP_WIDTH-1:0] in_e,
    input  logic [LEN_W-1:0]     in_e_len,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r,
    input  logic [WIDTH-1:0]     in_r2,
    output logic                 mont_start,
    output logic [WIDTH-1:0]     mont_a,
    output logic [WIDTH-1:0]     mont_b,
    output logic [WIDTH-1:0]     mont_m,
    input  logic [WIDTH-1:0]     mont_result,
    input  logic                 mont_done,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 done
);
    localparam int               IDX_W = LEN_W - 1;
    localparam logic [LEN_W-1:0] E_MAX = LEN_W'(EXP_WIDTH);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TOMONT   = 3'd1,
        ST_SQR      = 3'd2,
        ST_MUL      = 3'd3,
        ST_FROMMONT = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // GUARD is the cycle after ISSUE, where a level-high done from the previous op may linger
    typedef enum logic [1:0] {
        PH_ISSUE = 2'd0,
        PH_GUARD = 2'd1,
        PH_WAIT  = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_SQR  = 2'd1,
        OP_MUL  = 2'd2,
        OP_FROM = 2'd3
    } op_t;

    state_t               state_r, state_nxt_s;
    phase_t               phase_r, phase_nxt_s;
    op_t                  op_s;
    logic [EXP_WIDTH-1:0] e_r, e_nxt_s;
    logic [LEN_W-1:0]     e_len_r, e_len_nxt_s;
    logic [IDX_W-1:0]     i_r, i_nxt_s;
    logic [WIDTH-1:0]     acc_r, acc_nxt_s;
    logic [WIDTH-1:0]     xt_r, xt_nxt_s;
    logic                 mont_start_r, mont_start_nxt_s;
    logic [WIDTH-1:0]     mont_a_r, mont_a_nxt_s;
    logic [WIDTH-1:0]     mont_b_r, mont_b_nxt_s;
    logic [WIDTH-1:0]     mont_m_r, mont_m_nxt_s;
    logic [WIDTH-1:0]     result_r, result_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 done_r, done_nxt_s;

    assign mont_start = mont_start_r;
    assign mont_a     = mont_a_r;
    assign mont_b     = mont_b_r;
    assign mont_m     = mont_m_r;
    assign result     = result_r;
    assign busy       = busy_r;
    assign done       = done_r;

    // Next-state, operand selection and output values for the sequencer
    always_comb begin
        state_nxt_s      = state_r;
        phase_nxt_s      = phase_r;
        op_s             = OP_NONE;
        e_nxt_s          = e_r;
        e_len_nxt_s      = e_len_r;
        i_nxt_s          = i_r;
        acc_nxt_s        = acc_r;
        xt_nxt_s         = xt_r;
        mont_start_nxt_s = 1'b0;
        mont_a_nxt_s     = mont_a_r;
        mont_b_nxt_s     = mont_b_r;
        mont_m_nxt_s     = mont_m_r;
        result_nxt_s     = result_r;
        busy_nxt_s       = busy_r;
        done_nxt_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    e_nxt_s          = in_e;
                    e_len_nxt_s      = (in_e_len > E_MAX) ? E_MAX : in_e_len;
                    i_nxt_s          = '0;
                    acc_nxt_s        = in_r;
                    xt_nxt_s         = '0;
                    mont_m_nxt_s     = in_m;
                    mont_a_nxt_s     = in_x;
                    mont_b_nxt_s     = in_r2;
                    mont_start_nxt_s = 1'b1;
                    phase_nxt_s      = PH_ISSUE;
                    busy_nxt_s       = 1'b1;
                    state_nxt_s      = ST_TOMONT;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            ST_TOMONT, ST_SQR, ST_MUL, ST_FROMMONT: begin
                case (phase_r)
                    PH_ISSUE: phase_nxt_s = PH_GUARD;
                    PH_GUARD: phase_nxt_s = PH_WAIT;
                    default: begin
                        if (mont_done) begin
                            case (state_r)
                                ST_TOMONT: begin
                                    xt_nxt_s = mont_result;
                                    if (e_len_r == LEN_W'(0)) begin
                                        op_s = OP_FROM;
                                    end else begin
                                        i_nxt_s = IDX_W'(e_len_r - LEN_W'(1));
                                        op_s    = OP_SQR;
                                    end
                                end
                                ST_SQR: begin
                                    acc_nxt_s = mont_result;
                                    if (e_r[i_r]) begin
                                        op_s = OP_MUL;
                                    end else if (i_r == IDX_W'(0)) begin
                                        op_s = OP_FROM;
                                    end else begin
                                        i_nxt_s = i_r - IDX_W'(1);
                                        op_s    = OP_SQR;
                                    end
                                end
                                ST_MUL: begin
                                    acc_nxt_s = mont_result;
                                    if (i_r == IDX_W'(0)) begin
                                        op_s = OP_FROM;
                                    end else begin
                                        i_nxt_s = i_r - IDX_W'(1);
                                        op_s    = OP_SQR;
                                    end
                                end
                                default: begin
                                    acc_nxt_s    = mont_result;
                                    result_nxt_s = mont_result;
                                    busy_nxt_s   = 1'b0;
                                    done_nxt_s   = 1'b1;
                                    phase_nxt_s  = PH_ISSUE;
                                    state_nxt_s  = ST_DONE;
                                end
                            endcase
                        end else begin
                            phase_nxt_s = PH_WAIT;
                        end
                    end
                endcase
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: begin
                busy_nxt_s  = 1'b0;
                phase_nxt_s = PH_ISSUE;
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Launch the next multiplier op; operand A is always the updated accumulator
        case (op_s)
            OP_SQR: begin
                mont_start_nxt_s = 1'b1;
                phase_nxt_s      = PH_ISSUE;
                mont_a_nxt_s     = acc_nxt_s;
                mont_b_nxt_s     = acc_nxt_s;
                state_nxt_s      = ST_SQR;
            end
            OP_MUL: begin
                mont_start_nxt_s = 1'b1;
                phase_nxt_s      = PH_ISSUE;
                mont_a_nxt_s     = acc_nxt_s;
                mont_b_nxt_s     = xt_nxt_s;
                state_nxt_s      = ST_MUL;
            end
            OP_FROM: begin
                mont_start_nxt_s = 1'b1;
                phase_nxt_s      = PH_ISSUE;
                mont_a_nxt_s     = acc_nxt_s;
                mont_b_nxt_s     = ONE_W;
                state_nxt_s      = ST_FROMMONT;
            end
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            phase_r      <= PH_ISSUE;
            e_r          <= '0;
            e_len_r      <= '0;
            i_r          <= '0;
            acc_r        <= '0;
            xt_r         <= '0;
            mont_start_r <= 1'b0;
            mont_a_r     <= '0;
            mont_b_r     <= '0;
            mont_m_r     <= '0;
            result_r     <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            phase_r      <= phase_nxt_s;
            e_r          <= e_nxt_s;
            e_len_r      <= e_len_nxt_s;
            i_r          <= i_nxt_s;
            acc_r        <= acc_nxt_s;
            xt_r         <= xt_nxt_s;
            mont_start_r <= mont_start_nxt_s;
            mont_a_r     <= mont_a_nxt_s;
            mont_b_r     <= mont_b_nxt_s;
            mont_m_r     <= mont_m_nxt_s;
            result_r     <= result_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

endmodule
